// File: rtl/axi_slave_ram_if.sv
// AXI4 read-only bundle (AR + R channels) between a read master and axi_slave_ram.
// Latency: none, wires only.
// Backpressure: arvalid/arready on AR and rvalid/rready on R, standard AXI semantics.
interface axi_slave_ram_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) ();

  // read address channel
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;

  // read data channel
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 read-only slave over a reset-loaded byte RAM (byte i = i[7:0]); FIXED/INCR/WRAP bursts.
// Latency: first R beat the cycle after the AR handshake, then one beat per cycle with rready high.
// Backpressure: R beat held stable while rready is low; arready low for the whole burst (no AR/R overlap).
// Optional feature macro AXI_SLAVE_RAM_SLVERR_EN: flag illegal bursts with SLVERR instead of sanitising them.
module axi_slave_ram #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  axi_slave_ram_if.slave s_axi
);

  localparam int         NBYTES   = DATA_WIDTH / 8;
  localparam int         DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(NBYTES));

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [1:0] BT_FIXED = 2'd0;
  localparam logic [1:0] BT_INCR  = 2'd1;
  localparam logic [1:0] BT_WRAP  = 2'd2;
  localparam logic [1:0] BT_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  // Everything the R side needs about the burst in flight. mode is the
  // already-sanitised burst type, so the address stepper never sees RSVD
  // or an illegal WRAP.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               mode;
    logic                     err;
  } burst_t;

  logic [7:0]               ram [DEPTH];

  logic [0:0]               state_q, state_d;
  burst_t                   ctx_q, ctx_d;
  burst_t                   ar_ctx;
  logic [7:0]               beat_q, beat_d;
  logic                     arready_q;

  logic                     wrap_len_ok;
  logic [2:0]               ar_size_eff;
  logic [31:0]              ar_window;

  logic [ADDRESS_WIDTH-1:0] step;
  logic [ADDRESS_WIDTH-1:0] addr_inc;
  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [ADDRESS_WIDTH-1:0] aligned;
  logic [DATA_WIDTH-1:0]    word;

  logic                     rvalid_w;
  logic                     rlast_w;
  logic                     beat_done;

  // RAM pattern: reloaded on every reset, never written otherwise
  for (genvar i = 0; i < DEPTH; i++) begin : g_ram
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        ram[i] <= 8'(i);
      end
    end
  end

  // Decode the AR request into a sanitised burst context
  always_comb begin
    ar_ctx      = '0;
    wrap_len_ok = (s_axi.arlen == 8'd1) || (s_axi.arlen == 8'd3) ||
                  (s_axi.arlen == 8'd7) || (s_axi.arlen == 8'd15);
`ifdef AXI_SLAVE_RAM_SLVERR_EN
    // Illegal requests still return len+1 beats; they step as INCR with the
    // requested size so beat count and rlast behave normally.
    ar_size_eff = s_axi.arsize;
    ar_ctx.err  = (s_axi.arburst == BT_RSVD) || (s_axi.arsize > MAX_SIZE) ||
                  ((s_axi.arburst == BT_WRAP) && !wrap_len_ok);
    ar_ctx.mode = ar_ctx.err ? BT_INCR : s_axi.arburst;
`else
    // Illegal requests are quietly turned into something servable.
    ar_size_eff = (s_axi.arsize > MAX_SIZE) ? MAX_SIZE : s_axi.arsize;
    ar_ctx.err  = 1'b0;
    if ((s_axi.arburst == BT_RSVD) || ((s_axi.arburst == BT_WRAP) && !wrap_len_ok)) begin
      ar_ctx.mode = BT_INCR;
    end else begin
      ar_ctx.mode = s_axi.arburst;
    end
`endif
    ar_ctx.addr = s_axi.araddr;
    ar_ctx.len  = s_axi.arlen;
    ar_ctx.size = ar_size_eff;
    // Wrap window is (len+1) beats of 2^size bytes; a power of two for every
    // legal WRAP length, so the window offset is a simple mask. A window
    // larger than the RAM truncates to all-ones and just rolls over.
    ar_window        = (32'(s_axi.arlen) + 32'd1) << ar_size_eff;
    ar_ctx.wrap_mask = ADDRESS_WIDTH'(ar_window - 32'd1);
  end

  // Address of the next beat for the burst in flight
  always_comb begin
    step     = ADDRESS_WIDTH'(32'd1 << ctx_q.size);
    addr_inc = ctx_q.addr + step;
    case (ctx_q.mode)
      BT_FIXED: next_addr = ctx_q.addr;
      BT_WRAP:  next_addr = (ctx_q.addr & ~ctx_q.wrap_mask) | (addr_inc & ctx_q.wrap_mask);
      default:  next_addr = addr_inc;
    endcase
  end

  // Full aligned word around the current address, little-endian byte lanes
  always_comb begin
    aligned = ctx_q.addr & ~ADDRESS_WIDTH'(NBYTES - 1);
    word    = '0;
    for (int k = 0; k < NBYTES; k++) begin
      word[8*k +: 8] = ram[aligned | ADDRESS_WIDTH'(k)];
    end
  end

  assign rvalid_w  = (state_q == ST_BURST);
  assign rlast_w   = rvalid_w && (beat_q == ctx_q.len);
  assign beat_done = rvalid_w && s_axi.rready;

  // Burst sequencing: accept one AR in IDLE, stream beats in BURST
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          state_d = ST_BURST;
          ctx_d   = ar_ctx;
          beat_d  = 8'd0;
        end
      end
      ST_BURST: begin
        if (beat_done) begin
          if (rlast_w) begin
            state_d = ST_IDLE;
          end else begin
            beat_d     = beat_q + 8'd1;
            ctx_d.addr = next_addr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any burst on the spot
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      beat_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      beat_q  <= beat_d;
    end
  end

  // arready is registered so it stays low through reset and only rises on
  // the first edge after release, and again on the edge that ends a burst
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_q <= 1'b0;
    end else begin
      arready_q <= (state_d == ST_IDLE);
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_w;
  assign s_axi.rlast   = rlast_w;
  assign s_axi.rresp   = (rvalid_w && ctx_q.err) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.rdata   = (rvalid_w && !ctx_q.err) ? word : '0;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Bench for axi_slave_ram: directed vector table, async-reset abort sequence, random bursts vs model.
// Latency: expects first beat right after the AR handshake edge and back-to-back beats.
// Backpressure: drives rready always-high, toggling and random; checks data hold during stalls.
module tb_axi_slave_ram;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi_slave_ram_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_slave_ram #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axi   (axi)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_dat [256];
  logic [1:0]    exp_rsp;

  typedef struct packed {
    logic [7:0]          addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [1:0]          rmode;   // 0 always ready, 1 toggling, 2 random
    logic                hold;    // keep arvalid high during the burst
    logic [1:0]          rsp;
    logic [7:0][DW-1:0]  dat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input logic [1:0] rm, input logic h,
                              input logic [1:0] rsp,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] d4, input logic [31:0] d5,
                              input logic [31:0] d6, input logic [31:0] d7);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.rmode = rm; v.hold = h; v.rsp = rsp;
    v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
    v.dat[4] = d4; v.dat[5] = d5; v.dat[6] = d6; v.dat[7] = d7;
    return v;
  endfunction

  // Reference: AXI burst address rules evaluated per beat with plain arithmetic.
  function automatic void model(input int a, input int l, input int s, input int b);
    int  nb, kind, wsize, lower, addr, alg;
    bit  err, legal_wrap;
    logic [DW-1:0] w;
    err        = 1'b0;
    kind       = b;
    legal_wrap = (l == 1) || (l == 3) || (l == 7) || (l == 15);
`ifdef AXI_SLAVE_RAM_SLVERR_EN
    if (b == 3 || (1 << s) > NB || (b == 2 && !legal_wrap)) err = 1'b1;
    if (err) kind = 1;
    nb = 1 << s;
`else
    nb = ((1 << s) > NB) ? NB : (1 << s);
    if (b == 3 || (b == 2 && !legal_wrap)) kind = 1;
`endif
    exp_rsp = err ? 2'd2 : 2'd0;
    for (int i = 0; i <= l; i++) begin
      case (kind)
        0: addr = a;
        2: begin
          wsize = (l + 1) * nb;
          lower = (a / wsize) * wsize;
          addr  = (lower + ((a - lower) + i * nb) % wsize) % 256;
        end
        default: addr = (a + i * nb) % 256;
      endcase
      alg = addr - (addr % NB);
      w   = '0;
      for (int k = 0; k < NB; k++) w[8*k +: 8] = 8'((alg + k) % 256);
      exp_dat[i] = err ? '0 : w;
    end
  endfunction

  // Issue one burst and check every R cycle against exp_dat/exp_rsp.
  // Caller must be sitting 1 time unit after a rising edge.
  task automatic run_burst(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int rmode, input bit hold_ar,
                           input string tag);
    int  idx;
    bit  ok;
    bit  tog;
    axi.araddr  = a;
    axi.arlen   = l;
    axi.arsize  = s;
    axi.arburst = b;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      if (axi.arready) ok = 1'b1;
      @(posedge aclk); #1;
    end
    if (!ok) begin
      chk({tag, " ar_timeout"}, 64'd0, 64'd1);
      axi.arvalid = 1'b0;
      return;
    end
    if (hold_ar) axi.araddr = ~a;
    else         axi.arvalid = 1'b0;
    idx = 0;
    tog = 1'b0;
    for (int cyc = 0; cyc < (int'(l) + 1) * 10 + 20 && idx <= int'(l); cyc++) begin
      case (rmode)
        0:       axi.rready = 1'b1;
        1:       begin axi.rready = tog; tog = ~tog; end
        default: axi.rready = ($urandom_range(0, 3) != 0);
      endcase
      chk($sformatf("%s b%0d rvalid", tag, idx), 64'(axi.rvalid), 64'd1);
      if (!axi.rvalid) break;
      chk($sformatf("%s b%0d arready", tag, idx), 64'(axi.arready), 64'd0);
      chk($sformatf("%s b%0d rdata", tag, idx), 64'(axi.rdata), 64'(exp_dat[idx]));
      chk($sformatf("%s b%0d rresp", tag, idx), 64'(axi.rresp), 64'(exp_rsp));
      chk($sformatf("%s b%0d rlast", tag, idx), 64'(axi.rlast), 64'(idx == int'(l)));
      if (axi.rready) idx++;
      @(posedge aclk); #1;
    end
    axi.rready  = 1'b0;
    axi.arvalid = 1'b0;
    chk({tag, " beats"}, 64'(idx), 64'(int'(l) + 1));
    chk({tag, " rvalid_end"}, 64'(axi.rvalid), 64'd0);
    chk({tag, " arready_end"}, 64'(axi.arready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ra, rl, rs, rb, rm;
    bit rh;
    int lens [5];
    lens[0] = 0; lens[1] = 1; lens[2] = 3; lens[3] = 7; lens[4] = 15;

    tbl[0] = mk(8'h00, 8'd4, 3'd0, 2'd1, 2'd0, 1'b0, 2'd0,
                32'h03020100, 32'h03020100, 32'h03020100, 32'h03020100,
                32'h07060504, 32'h0, 32'h0, 32'h0);
    tbl[1] = mk(8'h10, 8'd3, 3'd2, 2'd1, 2'd1, 1'b1, 2'd0,
                32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[2] = mk(8'h28, 8'd3, 3'd2, 2'd2, 2'd2, 1'b0, 2'd0,
                32'h2B2A2928, 32'h2F2E2D2C, 32'h23222120, 32'h27262524,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[3] = mk(8'h44, 8'd2, 3'd2, 2'd0, 2'd0, 1'b0, 2'd0,
                32'h47464544, 32'h47464544, 32'h47464544, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[4] = mk(8'hFC, 8'd1, 3'd2, 2'd1, 2'd1, 1'b0, 2'd0,
                32'hFFFEFDFC, 32'h03020100, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[5] = mk(8'h35, 8'd7, 3'd0, 2'd2, 2'd0, 1'b0, 2'd0,
                32'h37363534, 32'h37363534, 32'h37363534, 32'h33323130,
                32'h33323130, 32'h33323130, 32'h33323130, 32'h37363534);
    tbl[6] = mk(8'h60, 8'd0, 3'd1, 2'd1, 2'd1, 1'b0, 2'd0,
                32'h63626160, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
`ifdef AXI_SLAVE_RAM_SLVERR_EN
    tbl[7] = mk(8'h00, 8'd1, 3'd3, 2'd1, 2'd0, 1'b0, 2'd2,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[8] = mk(8'h08, 8'd1, 3'd2, 2'd3, 2'd0, 1'b0, 2'd2,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[9] = mk(8'h18, 8'd2, 3'd2, 2'd2, 2'd1, 1'b0, 2'd2,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
`else
    tbl[7] = mk(8'h00, 8'd1, 3'd3, 2'd1, 2'd0, 1'b0, 2'd0,
                32'h03020100, 32'h07060504, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[8] = mk(8'h08, 8'd1, 3'd2, 2'd3, 2'd0, 1'b0, 2'd0,
                32'h0B0A0908, 32'h0F0E0D0C, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[9] = mk(8'h18, 8'd2, 3'd2, 2'd2, 2'd1, 1'b0, 2'd0,
                32'h1B1A1918, 32'h1F1E1D1C, 32'h23222120, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0);
`endif

    axi.araddr  = '0;
    axi.arlen   = '0;
    axi.arsize  = '0;
    axi.arburst = '0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst arready", 64'(axi.arready), 64'd0);
    chk("rst rvalid", 64'(axi.rvalid), 64'd0);
    chk("rst rlast", 64'(axi.rlast), 64'd0);
    chk("rst rresp", 64'(axi.rresp), 64'd0);
    chk("rst rdata", 64'(axi.rdata), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst arready", 64'(axi.arready), 64'd1);
    chk("post_rst rvalid", 64'(axi.rvalid), 64'd0);

    // directed table
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) exp_dat[j] = tbl[i].dat[j];
      exp_rsp = tbl[i].rsp;
      run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst,
                int'(tbl[i].rmode), tbl[i].hold, $sformatf("vec%0d", i));
    end

    // async reset in the middle of an 8-beat burst
    axi.araddr  = 8'h80;
    axi.arlen   = 8'd7;
    axi.arsize  = 3'd2;
    axi.arburst = 2'd1;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    @(posedge aclk); #1;
    axi.arvalid = 1'b0;
    chk("abort b0 rdata", 64'(axi.rdata), 64'h83828180);
    @(posedge aclk); #1;
    chk("abort b1 rdata", 64'(axi.rdata), 64'h87868584);
    @(posedge aclk); #1;
    chk("abort b2 rdata", 64'(axi.rdata), 64'h8B8A8988);
    #2;
    aresetn = 1'b0;
    #1;
    chk("abort rvalid", 64'(axi.rvalid), 64'd0);
    chk("abort rlast", 64'(axi.rlast), 64'd0);
    chk("abort arready", 64'(axi.arready), 64'd0);
    chk("abort rdata", 64'(axi.rdata), 64'd0);
    @(posedge aclk); #1;
    chk("abort held rvalid", 64'(axi.rvalid), 64'd0);
    aresetn = 1'b1;
    axi.rready = 1'b0;
    @(posedge aclk); #1;
    chk("abort release arready", 64'(axi.arready), 64'd1);
    chk("abort release rvalid", 64'(axi.rvalid), 64'd0);
    model(32'h90, 3, 2, 1);
    run_burst(8'h90, 8'd3, 3'd2, 2'd1, 0, 1'b0, "after_abort");

    // random bursts against the model
    for (int n = 0; n < 40; n++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 3);
      rs = $urandom_range(0, 3);
      rl = ($urandom_range(0, 1) == 1) ? lens[$urandom_range(0, 4)] : $urandom_range(0, 15);
      rm = $urandom_range(0, 2);
      rh = ($urandom_range(0, 3) == 0);
      model(ra, rl, rs, rb);
      run_burst(8'(ra), 8'(rl), 3'(rs), 2'(rb), rm, rh, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_ram.md
# axi_slave_ram

AXI4 read-only slave backed by an internal byte-addressed RAM. Accepts one read-address transaction at a time on the AR channel and returns `arlen+1` beats on the R channel, supporting FIXED, INCR and WRAP bursts. RAM contents are loaded by reset with a deterministic pattern, so the block serves as a known-data target for AXI master and interconnect benches. There is no write channel.

## Interface
- `ADDRESS_WIDTH`, default 8: byte-address width; RAM depth is 2^ADDRESS_WIDTH bytes.
- `DATA_WIDTH`, default 32: R data width; must be a power-of-two multiple of 8, minimum 8.
- `aclk`  in  1  clock; all state updates on rising edge.
- `aresetn`  in  1  reset; asynchronous, active-low.
- `araddr`  in  ADDRESS_WIDTH  burst start byte address.
- `arlen`  in  8  beats minus one.
- `arsize`  in  3  bytes per beat = 2^arsize.
- `arburst`  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
- `arvalid`  in  1  address valid.
- `arready`  out  1  address accepted when high with `arvalid`.
- `rdata`  out  DATA_WIDTH  read data.
- `rresp`  out  2  0=OKAY, 2=SLVERR.
- `rlast`  out  1  final beat of burst.
- `rvalid`  out  1  R beat valid.
- `rready`  in  1  master accepts beat.

## Operation
- RAM: byte `i` holds `i[7:0]` after every reset. No write path.
- States: IDLE, BURST.
- IDLE: `arready=1`, `rvalid=0`. On `arvalid&&arready`, latch address, len, size and burst, set beat counter to 0, and go to BURST.
- BURST: `arready=0`; `rvalid=1`; `rdata` is the full aligned word at `addr & ~(DATA_WIDTH/8-1)`, little-endian, with byte lane k = RAM[aligned+k]. All lanes are driven; the master picks the valid lanes for narrow transfers.
- `rlast=1` when beat counter == latched len.
- On `rvalid&&rready`: if `rlast`, go to IDLE. Otherwise increment the counter and advance the address:
  - FIXED: address unchanged.
  - INCR: address += 2^size, modulo 2^ADDRESS_WIDTH.
  - WRAP: address += 2^size, then wraps within an aligned window of (len+1)*2^size bytes.
- Address arithmetic is ADDRESS_WIDTH bits wide and rolls over at the top of the RAM.
- `rresp=OKAY` unless an error condition applies (see Configuration).
- `rdata`, `rresp` and `rlast` are held stable while `rvalid && !rready`.

## Timing
- Reset values: `arready=0` while `aresetn` is low, 1 in the first cycle after release. `rvalid=0`, `rlast=0`, `rresp=0`, `rdata=0`. State is IDLE and the RAM pattern is reloaded.
- Address handshake at edge N: `rvalid=1` with beat 0 from edge N+1 (1-cycle latency).
- With `rready` held high, one beat per cycle.
- After the `rlast` handshake at edge M: `rvalid=0` and `arready=1` from edge M+1. There is no AR/R overlap.
- `arvalid` asserted during BURST is ignored until IDLE is reached.
- `aresetn` low mid-burst aborts the burst immediately (asynchronously). No further beats are issued.
- `arlen=0`: a single beat with `rlast=1`.

## Configuration
- `AXI_SLAVE_RAM_SLVERR_EN` defined:
  - `arburst=3` or 2^arsize > DATA_WIDTH/8 gives `rresp=SLVERR` and `rdata=0` for every beat of that burst. Beat count is still len+1.
  - WRAP with len not in {1,3,7,15} also gives SLVERR.
  - In error cases the address advances as INCR.
- Not defined:
  - `rresp` is always OKAY.
  - Oversized `arsize` is clamped to log2(DATA_WIDTH/8).
  - `arburst=3` is treated as INCR.
  - WRAP with an illegal len is treated as INCR.

## Test plan
- INCR, `araddr=0`, `arsize=0`, `arlen=4`, `rready=1` -> 5 beats: 0x03020100 four times, then 0x07060504 with `rlast=1`; `arready` returns next cycle.
- INCR, `araddr=0x10`, `arsize=2`, `arlen=3`, `rready` toggled every other cycle -> 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C. Data is held during stalls; `rlast` only on the 4th beat.
- WRAP, `araddr=0x28`, `arsize=2`, `arlen=3` -> words at 0x28, 0x2C, 0x20, 0x24 (0x2B2A2928 … 0x27262524).
- FIXED, `araddr=0x44`, `arlen=2` -> 0x47464544 three times; INCR at `araddr=0xFC`, `arsize=2`, `arlen=1` -> 0xFFFEFDFC then 0x03020100 (rollover).
- `aresetn` pulsed low during beat 2 of an 8-beat burst -> `rvalid=0` immediately. After release, `arready=1` and a new burst returns correct data.
- With `AXI_SLAVE_RAM_SLVERR_EN`, `arsize=3`, `arlen=1` -> 2 beats, `rresp=2`, `rdata=0`. Without it: OKAY with clamped data 0x03020100, 0x07060504.
